// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Summary  : Shared encodings for the FIFO-backed UART transmitter.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP1    = 3'd4,
        ST_STOP2    = 3'd5,
        ST_BREAK    = 3'd6,
        ST_BRK_IDLE = 3'd7
    } tx_state_t;

    // Field order mirrors CTRL[4:0] so the byte can be cast directly
    typedef struct packed {
        logic       stop2;
        logic [1:0] par;
        logic [1:0] nbits;
    } fmt_t;

    localparam logic [2:0] ADR_DIV0   = 3'd0;
    localparam logic [2:0] ADR_TXDATA = 3'd4;
    localparam logic [2:0] ADR_CTRL   = 3'd5;

    localparam logic [1:0] PAR_NONE   = 2'b00;
    localparam logic [1:0] PAR_EVEN   = 2'b01;
    localparam logic [1:0] PAR_ODD    = 2'b10;
    localparam logic [1:0] PAR_NONE2  = 2'b11;

    localparam int CTRL_FLUSH = 6;
    localparam int CTRL_BREAK = 7;

    function automatic logic has_parity(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] nbits_m5,
                                        input logic [1:0] par);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - nbits_m5);
        return (^(data & mask)) ^ (par == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_bus_if.sv
`default_nettype none
// ============================================================================
// Interface: uart_tx_fifo_bus_if
// Summary  : Peripheral write bus plus transmitter status for uart_tx_fifo_bus.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_bus_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       adr;
    logic [7:0]       din;
    logic             wr_en;
    logic             tx_busy;
    logic             tx_full;
    logic             tx_empty;
    logic [LVL_W-1:0] tx_level;
    logic             tx_ovf;

    modport master (
        output adr, din, wr_en,
        input  tx_busy, tx_full, tx_empty, tx_level, tx_ovf
    );

    modport slave (
        input  adr, din, wr_en,
        output tx_busy, tx_full, tx_empty, tx_level, tx_ovf
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Synchronous FIFO, head entry readable combinationally.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 8
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          push,
    input  wire logic                          pop,
    input  wire logic                          flush,
    input  wire logic [WIDTH-1:0]              wdata,
    output logic      [WIDTH-1:0]              rdata,
    output logic                               full,
    output logic                               empty,
    output logic      [$clog2(FIFO_DEPTH):0]   level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign level     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_do_push = push && !flush && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_bus.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_bus
// Summary  : Bus-mapped UART transmitter with TX FIFO, 5-8 data bits, parity,
//            1/2 stop bits. Break generation enabled by UART_TX_BREAK_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo_bus
    import uart_pkg::*;
#(
    parameter int               FIFO_DEPTH = 16,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(16'hFFFF)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_fifo_bus_if.slave bus,
    output logic              tx_p
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LANES = DIV_W / 8;

    logic [DIV_W-1:0] r_div;
    fmt_t             r_fmt;
    logic             r_ovf;
    logic             w_brk;
    logic             w_wr_txdata;
    logic             w_wr_ctrl;
    logic             w_flush;

    logic [7:0]       w_fifo_rdata;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_lim;
    logic [2:0]       r_bitidx;
    logic [2:0]       w_bitidx_nxt;
    logic [2:0]       w_last_idx;
    logic [7:0]       r_data;
    fmt_t             r_fmt_f;
    logic [DIV_W-1:0] r_div_f;
    logic             r_par_bit;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             w_pop;
    logic             w_frame_end;
    logic             w_bit_end;

    assign w_wr_txdata = bus.wr_en && (bus.adr == ADR_TXDATA);
    assign w_wr_ctrl   = bus.wr_en && (bus.adr == ADR_CTRL);
    assign w_flush     = w_wr_ctrl && bus.din[CTRL_FLUSH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= DIV_RESET;
            r_fmt <= '0;
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wr_en && (int'(bus.adr) == int'(ADR_DIV0) + i))
                    r_div[8*i +: 8] <= bus.din;
            end
            if (w_wr_ctrl)
                r_fmt <= fmt_t'(bus.din[4:0]);
            if (w_wr_ctrl)
                r_ovf <= 1'b0;
            else if (w_wr_txdata && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

`ifdef UART_TX_BREAK_EN
    logic r_brk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_brk <= 1'b0;
        else if (w_wr_ctrl)
            r_brk <= bus.din[CTRL_BREAK];
    end

    assign w_brk = r_brk;
`else
    assign w_brk = 1'b0;
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_txdata),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (bus.din),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Break recovery times against the live divider; frames use their snapshot
    assign w_lim      = (r_state == ST_BRK_IDLE) ? r_div : r_div_f;
    assign w_bit_end  = (r_cnt == w_lim);
    assign w_last_idx = 3'd4 + {1'b0, r_fmt_f.nbits};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + DIV_W'(1);
        w_bitidx_nxt = r_bitidx;
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (w_brk) begin
                    w_state_nxt = ST_BREAK;
                    w_tx_nxt    = 1'b0;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt    = '0;
                    w_bitidx_nxt = '0;
                    w_state_nxt  = ST_DATA;
                    w_tx_nxt     = r_data[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bitidx == w_last_idx) begin
                        if (has_parity(r_fmt_f.par)) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = ST_STOP1;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bitidx_nxt = r_bitidx + 3'd1;
                        w_tx_nxt     = r_data[r_bitidx + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STOP1;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP1: begin
                if (w_bit_end) begin
                    if (r_fmt_f.stop2) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STOP2;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (w_bit_end) w_frame_end = 1'b1;
            end
            ST_BREAK: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b0;
                if (!w_brk) begin
                    w_state_nxt = ST_BRK_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_BRK_IDLE: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Chain straight into the next start bit so frames run back-to-back
        if (w_frame_end) begin
            w_cnt_nxt = '0;
            if (w_brk) begin
                w_state_nxt = ST_BREAK;
                w_tx_nxt    = 1'b0;
            end else if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_START;
                w_tx_nxt    = 1'b0;
            end else begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bitidx  <= '0;
            r_tx      <= 1'b1;
            r_data    <= '0;
            r_fmt_f   <= '0;
            r_div_f   <= DIV_RESET;
            r_par_bit <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_tx     <= w_tx_nxt;
            if (w_pop) begin
                r_data    <= w_fifo_rdata;
                r_fmt_f   <= r_fmt;
                r_div_f   <= r_div;
                r_par_bit <= parity_bit(w_fifo_rdata, r_fmt.nbits, r_fmt.par);
            end
        end
    end

    assign tx_p         = r_tx;
    assign bus.tx_busy  = (r_state != ST_IDLE) || !w_empty;
    assign bus.tx_full  = w_full;
    assign bus.tx_empty = w_empty;
    assign bus.tx_level = w_level;
    assign bus.tx_ovf   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_bus
// Summary  : Self-checking bench; line-level queue model of the UART framing.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo_bus;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int DIV_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_p;

    uart_tx_fifo_bus_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo_bus #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W),
        .DIV_RESET  (16'hFFFF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx_p (tx_p)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pending FIFO bytes and the per-cycle line levels of the frame in flight
    int          mq[$];
    bit          line_q[$];
    logic [15:0] m_div;
    logic [4:0]  m_ctrl;
    bit          m_ovf;
    bit          m_tx;
    bit          m_inframe;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_frame(input logic [7:0] b);
        int n;
        int ones;
        bit seq[$];
        n    = int'(m_ctrl[1:0]) + 5;
        ones = 0;
        seq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (m_ctrl[3:2] == 2'b01) seq.push_back(bit'(ones % 2));
        else if (m_ctrl[3:2] == 2'b10) seq.push_back(bit'((ones % 2) == 0));
        seq.push_back(1'b1);
        if (m_ctrl[4]) seq.push_back(1'b1);
        foreach (seq[k])
            for (int r = 0; r <= int'(m_div); r++) line_q.push_back(seq[k]);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                line_q.delete();
                m_div     = 16'hFFFF;
                m_ctrl    = '0;
                m_ovf     = 1'b0;
                m_tx      = 1'b1;
                m_inframe = 1'b0;
            end else begin
                bit pre_full;
                bit popped;
                pre_full = (mq.size() == DEPTH);
                popped   = 1'b0;
                if (line_q.size() > 0) begin
                    m_tx      = line_q.pop_front();
                    m_inframe = 1'b1;
                end else if (mq.size() > 0) begin
                    build_frame(8'(mq.pop_front()));
                    popped    = 1'b1;
                    m_tx      = line_q.pop_front();
                    m_inframe = 1'b1;
                end else begin
                    m_tx      = 1'b1;
                    m_inframe = 1'b0;
                end
                if (bus.wr_en) begin
                    if (bus.adr == 3'd0) m_div[7:0] = bus.din;
                    else if (bus.adr == 3'd1) m_div[15:8] = bus.din;
                    else if (bus.adr == 3'd4) begin
                        if (pre_full && !popped) m_ovf = 1'b1;
                        else mq.push_back(int'(bus.din));
                    end else if (bus.adr == 3'd5) begin
                        m_ctrl = bus.din[4:0];
                        m_ovf  = 1'b0;
                        if (bus.din[6]) mq.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx_p",     tx_p,         m_tx);
                check("tx_busy",  bus.tx_busy,  (m_inframe || mq.size() > 0));
                check("tx_level", bus.tx_level, mq.size());
                check("tx_full",  bus.tx_full,  (mq.size() == DEPTH));
                check("tx_empty", bus.tx_empty, (mq.size() == 0));
                check("tx_ovf",   bus.tx_ovf,   m_ovf);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.adr   = a;
        bus.din   = d;
        bus.wr_en = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic set_div(input int d);
        wr(3'd0, 8'(d));
        wr(3'd1, 8'(d >> 8));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.tx_busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", bus.tx_busy, 1'b0);
    endtask

    // Sends one byte into an idle transmitter and samples each bit mid-cell
    task automatic send_cap(input logic [7:0] b, input int nbits, input int div,
                            output logic [15:0] bits);
        wr(ADR_TXDATA, b);
        @(negedge clk);
        check("start_latency", tx_p, 1'b1);
        @(posedge clk); #1;
        bits = '0;
        for (int c = 0; c < nbits * (div + 1); c++) begin
            if ((c % (div + 1)) == div / 2) bits[c / (div + 1)] = tx_p;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bits;
        logic [7:0]  d;
        int          hi;
        bus.adr   = '0;
        bus.din   = '0;
        bus.wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx_p",  tx_p,         1'b1);
        check("rst_empty", bus.tx_empty, 1'b1);
        check("rst_full",  bus.tx_full,  1'b0);
        check("rst_level", bus.tx_level, 0);
        check("rst_ovf",   bus.tx_ovf,   1'b0);
        check("rst_busy",  bus.tx_busy,  1'b0);
        @(posedge clk); #1;

        // 8N1, 4 clocks per bit
        set_div(3);
        wr(ADR_CTRL, 8'h03);
        send_cap(8'hA5, 10, 3, bits);
        check("frame_a5_8n1", bits, 16'h034A);
        check("busy_after_stop", bus.tx_busy, 1'b0);

        // 7 data bits, even parity, 2 stop bits
        wr(ADR_CTRL, 8'h16);
        send_cap(8'h41, 11, 3, bits);
        check("frame_41_7e2", bits, 16'h0682);
        check("busy_after_7e2", bus.tx_busy, 1'b0);

        // 8 data bits, odd parity
        wr(ADR_CTRL, 8'h0B);
        send_cap(8'hFF, 11, 3, bits);
        check("frame_ff_8o1", bits, 16'h07FE);
        send_cap(8'h00, 11, 3, bits);
        check("frame_00_8o1", bits, 16'h0600);

        // Burst beyond capacity
        set_div(15);
        wr(ADR_CTRL, 8'h03);
        for (int i = 0; i < DEPTH + 2; i++) wr(ADR_TXDATA, 8'(8'h30 + i));
        check("burst_level", bus.tx_level, DEPTH);
        check("burst_full",  bus.tx_full,  1'b1);
        check("burst_ovf",   bus.tx_ovf,   1'b1);
        wr(ADR_CTRL, 8'h03);
        check("ovf_cleared", bus.tx_ovf, 1'b0);
        wait_idle(4000);
        idle_cycles(2);

        // Divider and flush mid-frame leave the frame in flight untouched
        set_div(3);
        wr(ADR_TXDATA, 8'h3C);
        wr(ADR_TXDATA, 8'h11);
        wr(ADR_TXDATA, 8'h22);
        idle_cycles(6);
        set_div(7);
        wr(ADR_CTRL, 8'h43);
        check("flush_level", bus.tx_level, 0);
        wait_idle(200);
        send_cap(8'h5A, 10, 7, bits);
        check("frame_5a_div7", bits, 16'h02B4);

        // Randomised traffic
        set_div($urandom_range(0, 4));
        wr(ADR_CTRL, 8'($urandom_range(0, 31)));
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 4) < 2) begin
                logic [2:0] a;
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 3'd0) d = 8'($urandom_range(0, 4));
                if (a == 3'd1) d = 8'h00;
                if (a == 3'd5) begin
                    d[7] = 1'b0;
                    d[5] = 1'b0;
                    d[6] = ($urandom_range(0, 9) == 0);
                end
                wr(a, d);
            end else begin
                idle_cycles(1);
            end
        end
        wait_idle(4000);

        // Asynchronous reset in the middle of a data bit
        set_div(3);
        wr(ADR_CTRL, 8'h03);
        wr(ADR_TXDATA, 8'h00);
        wr(ADR_TXDATA, 8'h66);
        wr(ADR_TXDATA, 8'h77);
        idle_cycles(4);
        @(negedge clk);
        chk_en = 1'b0;
        check("pre_rst_tx_p",  tx_p,         1'b0);
        check("pre_rst_empty", bus.tx_empty, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_tx_p",  tx_p,         1'b1);
        check("async_rst_empty", bus.tx_empty, 1'b1);
        check("async_rst_level", bus.tx_level, 0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;

`ifdef UART_TX_BREAK_EN
        chk_en = 1'b0;
        set_div(3);
        wr(ADR_CTRL, 8'h83);
        idle_cycles(3);
        check("break_low",  tx_p,        1'b0);
        check("break_busy", bus.tx_busy, 1'b1);
        wr(ADR_TXDATA, 8'h12);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_p) hi++;
            idle_cycles(1);
        end
        check("break_held", hi, 0);
        check("break_no_pop", bus.tx_level, 1);
        wr(ADR_CTRL, 8'h03);
        hi = 0;
        for (int i = 0; i < 100 && (tx_p || hi == 0); i++) begin
            if (tx_p) hi++;
            idle_cycles(1);
        end
        check("break_recovery", (hi >= 4), 1'b1);
        wait_idle(200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
